// File: rtl/tree_arbiter_param.sv
// tree_arbiter_param: binary tree of 2-way arbitration cells granting one of 2**LEVELS clients.
// Optional macro TREE_ARB_EXT_ROOT_EN exposes root_req/root_ack to cascade into an outer arbiter.
module tree_arbiter_param #(
    parameter int LEVELS        = 3,
    parameter int PRIORITY_MODE = 0,
    parameter int ID_W          = LEVELS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2**LEVELS-1:0] req,
    output logic [2**LEVELS-1:0] ack,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id
`ifdef TREE_ARB_EXT_ROOT_EN
    ,
    output logic                 root_req,
    input  logic                 root_ack
`endif
);
    localparam int N = 2**LEVELS;
    typedef enum logic [2:0] {I1 = 3'd0, I2 = 3'd1, R1 = 3'd2, R2 = 3'd3, A1 = 3'd4, A2 = 3'd5} state_t;
    // Heap numbering: node 1 is the root, node n feeds from 2n/2n+1, clients are nodes N..2N-1.
    state_t st [1:N-1];
    logic [2*N-1:1] up, dn;
    always_comb begin
        up = '0;
        for (int n = 1; n < N; n++) up[n] = st[n] inside {R1, R2, A1, A2};
        up[2*N-1:N] = req;
    end
    always_comb begin
        dn = '0;
`ifdef TREE_ARB_EXT_ROOT_EN
        dn[1] = root_ack;
`else
        dn[1] = up[1];
`endif
        for (int n = 1; n < N; n++) begin
            dn[2*n]   = st[n] == A1;
            dn[2*n+1] = st[n] == A2;
        end
    end
    assign ack         = dn[2*N-1:N];
    assign grant_valid = |ack;
`ifdef TREE_ARB_EXT_ROOT_EN
    assign root_req    = up[1];
`endif
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < N; i++) if (ack[i]) grant_id = grant_id | ID_W'(i);
    end
    always_ff @(posedge clk) begin
        for (int n = 1; n < N; n++) begin
            if (rst) st[n] <= I1;
            else begin
                case (st[n])
                    I1:      st[n] <= up[2*n] ? R1 : up[2*n+1] ? R2 : I1;
                    I2:      st[n] <= up[2*n+1] ? R2 : up[2*n] ? R1 : I2;
                    R1:      st[n] <= dn[n] ? A1 : R1;
                    R2:      st[n] <= dn[n] ? A2 : R2;
                    A1:      st[n] <= up[2*n] ? A1 : (PRIORITY_MODE == 1 ? I1 : I2);
                    A2:      st[n] <= up[2*n+1] ? A2 : I1;
                    default: st[n] <= I1;
                endcase
            end
        end
    end
endmodule
